branch_resolver: RTL
====================

Name: branch_resolver

Overview:
- Execute-side counterpart of the branch predictor.
- Holds every predicted conditional branch from decode until execute resolves it.
- Produces the registered feedback record the predictor trains on, plus the mispredict redirect.
- Flushes wrong-path entries and keeps predicted/mispredicted branch statistics.
- Sits between the decode-stage prediction request and the hazard controller/predictor feedback port.

Parameters:
DEPTH, 4, number of in-flight branch entries; power of two, >= 2
ADDR_WIDTH, `ADDR_WIDTH (32), PC/target width
CNT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock
rst_n  in  1  reset
i_push_valid  in  1  decode has a predicted conditional (non-jump) branch this cycle
i_push_pc  in  ADDR_WIDTH  decode PC of that branch
i_push_prediction  in  BranchOutcome  prediction issued for it
i_push_recovery_target  in  ADDR_WIDTH  redirect target if prediction is wrong
o_full  out  1  queue full; hazard controller stalls decode
o_empty  out  1  queue empty
o_count  out  $clog2(DEPTH)+1  current occupancy
i_res_valid  in  1  execute resolves the oldest branch this cycle
i_res_outcome  in  BranchOutcome  actual outcome
o_fb_valid  out  1  feedback record valid (one-cycle pulse)
o_fb_pc  out  ADDR_WIDTH  PC of resolved branch
o_fb_prediction  out  BranchOutcome  stored prediction
o_fb_outcome  out  BranchOutcome  actual outcome
o_redirect_valid  out  1  mispredict; fetch must redirect (one-cycle pulse)
o_redirect_pc  out  ADDR_WIDTH  recovery target of mispredicted branch
o_branch_count  out  CNT_WIDTH  resolved branches, saturating
o_miss_count  out  CNT_WIDTH  mispredicted branches, saturating
o_err  out  2  sticky flags: [0] push while full, [1] resolve while empty

Behaviour:
- Reset:
  - Reset is rst_n, synchronous, active-low; clock is clk.
  - At reset, pointers = 0, o_count = 0, o_empty = 1, o_full = 0.
  - All fb/redirect outputs are 0, with BranchOutcome outputs = NOT_TAKEN.
  - Counters = 0, o_err = 0.
  - Reset mid-operation discards all entries with no feedback emitted.
- Storage:
  - Circular buffer of DEPTH entries {pc, prediction, recovery_target}.
  - rd/wr pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked in a separate counter.
  - o_full = (count == DEPTH); o_empty = (count == 0). Both are combinational from registered count.
- Push:
  - i_push_valid & ~o_full writes the entry at wr_ptr; wr_ptr++ and count++ at the clock edge.
  - Push while full drops the entry and sets o_err[0].
- Resolve:
  - i_res_valid & ~o_empty reads the head entry.
  - Next cycle (1-cycle latency): o_fb_valid = 1, o_fb_pc/o_fb_prediction from the entry, o_fb_outcome = i_res_outcome.
  - rd_ptr++ and count--.
  - o_branch_count increments (saturates at all-ones).
- Mispredict:
  - If the stored prediction != i_res_outcome: o_redirect_valid = 1 and o_redirect_pc = stored recovery_target, in the same cycle as o_fb_valid.
  - o_miss_count increments (saturating).
  - All younger entries are flushed at the same edge: wr_ptr <= rd_ptr+1, count <= 0.
  - A push in that same cycle is discarded (wrong path) and does not set o_err.
- Resolve while empty: ignored; no fb/redirect pulse; sets o_err[1].
- Simultaneous push and correct resolve: both take effect; count unchanged. This is legal even when full, since the pop frees a slot the same edge; no o_err.
- Outputs o_fb_* and o_redirect_pc hold their last value when the valid is low. Only the valids are pulses.
- Statistics counters never wrap; o_err clears only on reset.

Decomposition:
- Add to mips_core_pkg:
  - typedef struct packed branch_entry_t {pc, prediction, recovery_target}.
  - Reuse the existing BranchOutcome enum.
- One sub-module: branch_fifo.
  - Parameterised DEPTH/entry-type circular buffer with push, pop and flush_younger inputs, and count/full/empty outputs.
  - branch_resolver wraps it with compare, feedback registers, redirect and counters.

Test Plan:
- Reset, then push pc=0x100 pred=TAKEN rt=0x108, then resolve TAKEN -> next cycle fb_valid=1, fb_pc=0x100, fb_outcome=TAKEN, redirect_valid=0, branch_count=1, miss_count=0, count=0.
- Push 0x200 pred=NOT_TAKEN rt=0x240, then push 0x300, 0x400; resolve NOT_TAKEN→TAKEN mismatch on 0x200 while pushing 0x500 -> redirect_valid=1, redirect_pc=0x240, miss_count=1, count=0 next cycle, 0x500 discarded, o_err=0.
- Push 4 entries (DEPTH=4) -> o_full=1; fifth push -> o_err[0]=1, count stays 4. Then push plus correct resolve same cycle -> count stays 4, FIFO order preserved over 6 resolves including pointer wrap.
- Resolve with queue empty -> no fb_valid, o_err[1]=1, counters unchanged.
- Assert rst_n=0 with 3 entries queued and resolve pending -> following cycle count=0, fb_valid=0, counters=0, o_err=0.
- Force o_branch_count to all-ones via 2^CNT_WIDTH−1 resolves (CNT_WIDTH=4 build: 15) -> the 16th resolve leaves count at 15.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome encoding and the in-flight branch record
// held by the execute-side branch resolver.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

  localparam int PC_W = `ADDR_WIDTH;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    BranchOutcome    prediction;
    logic [PC_W-1:0] recovery_target;
  } branch_entry_t;

endpackage

// File: rtl/branch_fifo.sv
// Circular buffer of in-flight branch records with a flush that keeps only
// the head being popped, discarding everything younger.
module branch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush_younger,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_younger) begin
      // The head is consumed and every younger slot is reclaimed.
      rd_ptr  <= rd_ptr + 1'b1;
      wr_ptr  <= rd_ptr + 1'b1;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush_younger) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/branch_resolver.sv
// Tracks predicted conditional branches until execute resolves them, emits
// the predictor training record, the mispredict redirect and statistics.
module branch_resolver
  import mips_core_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push_valid,
  input  logic [ADDR_WIDTH-1:0]    i_push_pc,
  input  BranchOutcome             i_push_prediction,
  input  logic [ADDR_WIDTH-1:0]    i_push_recovery_target,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  input  logic                     i_res_valid,
  input  BranchOutcome             i_res_outcome,
  output logic                     o_fb_valid,
  output logic [ADDR_WIDTH-1:0]    o_fb_pc,
  output BranchOutcome             o_fb_prediction,
  output BranchOutcome             o_fb_outcome,
  output logic                     o_redirect_valid,
  output logic [ADDR_WIDTH-1:0]    o_redirect_pc,
  output logic [CNT_WIDTH-1:0]     o_branch_count,
  output logic [CNT_WIDTH-1:0]     o_miss_count,
  output logic [1:0]               o_err
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  branch_entry_t push_entry;
  branch_entry_t head;
  logic          res_ok;
  logic          mispredict;
  logic          push_ok;
  logic          push_drop;

  assign push_entry = '{pc: i_push_pc, prediction: i_push_prediction,
                        recovery_target: i_push_recovery_target};

  assign res_ok     = i_res_valid && !o_empty;
  assign mispredict = res_ok && (head.prediction != i_res_outcome);
  // A full queue still accepts a push when a correct resolve frees the head.
  assign push_ok    = i_push_valid && !mispredict && (!o_full || res_ok);
  assign push_drop  = i_push_valid && o_full && !res_ok;

  branch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (branch_entry_t)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (push_ok),
    .push_data     (push_entry),
    .pop           (res_ok),
    .flush_younger (mispredict),
    .head          (head),
    .count         (o_count),
    .full          (o_full),
    .empty         (o_empty)
  );

  // Stage p1: feedback/redirect registers, one cycle after resolve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_fb_valid       <= 1'b0;
      o_fb_pc          <= '0;
      o_fb_prediction  <= NOT_TAKEN;
      o_fb_outcome     <= NOT_TAKEN;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
      o_branch_count   <= '0;
      o_miss_count     <= '0;
      o_err            <= 2'b00;
    end else begin
      o_fb_valid       <= res_ok;
      o_redirect_valid <= mispredict;
      if (res_ok) begin
        o_fb_pc         <= head.pc;
        o_fb_prediction <= head.prediction;
        o_fb_outcome    <= i_res_outcome;
        o_branch_count  <= sat_inc(o_branch_count);
      end
      if (mispredict) begin
        o_redirect_pc <= head.recovery_target;
        o_miss_count  <= sat_inc(o_miss_count);
      end
      if (push_drop)                o_err[0] <= 1'b1;
      if (i_res_valid && o_empty)   o_err[1] <= 1'b1;
    end
  end

endmodule
